// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one single-port imem array between the core fetch port and the loader port.
// Latency: grant is combinational in the request cycle; rvalid/rdata/err follow exactly 1 cycle later.
// Backpressure: requesters hold req until gnt; loader wins ties, fetch is forced after MAX_LD_BURST loader grants.
// Option: define IMEM_WR_LOCK_EN to lock out loader writes from the first fetch grant after reset.
// Ports: clk/rst; fetch port i_fetch_* / o_fetch_*; loader port i_ld_* / o_ld_*; array port o_mem_* / i_mem_rdata.
module imem_port_arbiter #(
   parameter int          MEM_DEPTH    = 2048,
   parameter int          AW           = $clog2(MEM_DEPTH),
   parameter int          MAX_LD_BURST = 4,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_fetch_req,
   input  logic [31:0]   i_fetch_addr,
   output logic          o_fetch_gnt,
   output logic          o_fetch_rvalid,
   output logic [31:0]   o_fetch_rdata,
   output logic          o_fetch_err,
   input  logic          i_ld_req,
   input  logic          i_ld_we,
   input  logic [31:0]   i_ld_addr,
   input  logic [31:0]   i_ld_wdata,
   output logic          o_ld_gnt,
   output logic          o_ld_rvalid,
   output logic [31:0]   o_ld_rdata,
   output logic          o_ld_err,
   output logic          o_mem_en,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [31:0]   o_mem_wdata,
   input  logic [31:0]   i_mem_rdata
);

   localparam int            CW        = $clog2(MAX_LD_BURST + 1);
   localparam logic [CW-1:0] BURST_MAX = CW'(MAX_LD_BURST);
   localparam logic [31:0]   DEPTH_W   = 32'(MEM_DEPTH);

   // response tag: which port owns the array output in the current cycle
   localparam logic [1:0] TAG_NONE  = 2'd0;
   localparam logic [1:0] TAG_FETCH = 2'd1;
   localparam logic [1:0] TAG_LOAD  = 2'd2;

   logic [CW-1:0] burst_cnt;
   logic [1:0]    tag;
   logic          rsp_err;
   logic          rsp_rd;      // loader response carries array read data
   logic          fetch_legal;
   logic          ld_legal;
   logic          fetch_wins;
   logic          ld_do;       // loader access actually reaches the array
   logic          wr_block;

   assign fetch_legal = (i_fetch_addr[1:0] == 2'b00) && ({2'b00, i_fetch_addr[31:2]} < DEPTH_W);
   assign ld_legal    = (i_ld_addr[1:0] == 2'b00) && ({2'b00, i_ld_addr[31:2]} < DEPTH_W);

   // Fetch only takes a contested cycle once the loader has used up its burst allowance.
   assign fetch_wins  = i_fetch_req && (!i_ld_req || (burst_cnt == BURST_MAX));

   // No grants while in reset, so nothing touches the array and no response is queued.
   assign o_fetch_gnt = !rst && fetch_wins;
   assign o_ld_gnt    = !rst && i_ld_req && !fetch_wins;

`ifdef IMEM_WR_LOCK_EN
   logic wr_lock;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_lock <= 1'b0;
      end else if (o_fetch_gnt) begin
         wr_lock <= 1'b1;
      end
   end

   assign wr_block = wr_lock && i_ld_we;
`else
   assign wr_block = 1'b0;
`endif

   assign ld_do       = o_ld_gnt && ld_legal && !wr_block;
   assign o_mem_en    = (o_fetch_gnt && fetch_legal) || ld_do;
   assign o_mem_we    = ld_do && i_ld_we;
   assign o_mem_addr  = o_fetch_gnt ? i_fetch_addr[AW+1:2] : i_ld_addr[AW+1:2];
   assign o_mem_wdata = i_ld_wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         tag       <= TAG_NONE;
         rsp_err   <= 1'b0;
         rsp_rd    <= 1'b0;
         burst_cnt <= '0;
      end else begin
         rsp_err <= o_fetch_gnt ? !fetch_legal : (o_ld_gnt && (!ld_legal || wr_block));
         rsp_rd  <= ld_do && !i_ld_we;

         if (o_fetch_gnt) begin
            tag <= TAG_FETCH;
         end else if (o_ld_gnt) begin
            tag <= TAG_LOAD;
         end else begin
            tag <= TAG_NONE;
         end

         // Counts loader grants taken while fetch is waiting; any fetch grant or idle fetch restarts it.
         if (!i_fetch_req || o_fetch_gnt) begin
            burst_cnt <= '0;
         end else if (o_ld_gnt && (burst_cnt != BURST_MAX)) begin
            burst_cnt <= burst_cnt + CW'(1);
         end
      end
   end

   assign o_fetch_rvalid = (tag == TAG_FETCH);
   assign o_fetch_err    = o_fetch_rvalid && rsp_err;
   assign o_fetch_rdata  = !o_fetch_rvalid ? 32'h0 : (rsp_err ? NOP_INSTR : i_mem_rdata);

   assign o_ld_rvalid    = (tag == TAG_LOAD);
   assign o_ld_err       = o_ld_rvalid && rsp_err;
   assign o_ld_rdata     = (o_ld_rvalid && rsp_rd) ? i_mem_rdata : 32'h0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: randomized + directed bench for imem_port_arbiter with a queue scoreboard.
// Latency: expects grants in the request cycle and responses exactly one cycle after the grant.
// Backpressure: requests are held until the reference arbitration rule says they are granted.
module tb_imem_port_arbiter;

   localparam int          MEM_DEPTH    = 2048;
   localparam int          AW           = 11;
   localparam int          MAX_LD_BURST = 4;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          f_req = 1'b0;
   logic [31:0]   f_addr = 32'h0;
   logic          l_req = 1'b0;
   logic          l_we = 1'b0;
   logic [31:0]   l_addr = 32'h0;
   logic [31:0]   l_wdata = 32'h0;
   logic          o_fetch_gnt, o_fetch_rvalid, o_fetch_err;
   logic [31:0]   o_fetch_rdata;
   logic          o_ld_gnt, o_ld_rvalid, o_ld_err;
   logic [31:0]   o_ld_rdata;
   logic          o_mem_en, o_mem_we;
   logic [AW-1:0] o_mem_addr;
   logic [31:0]   o_mem_wdata;
   logic [31:0]   i_mem_rdata = 32'h0;

   imem_port_arbiter #(
      .MEM_DEPTH(MEM_DEPTH), .AW(AW), .MAX_LD_BURST(MAX_LD_BURST), .NOP_INSTR(NOP_INSTR)
   ) dut (
      .clk(clk), .rst(rst),
      .i_fetch_req(f_req), .i_fetch_addr(f_addr), .o_fetch_gnt(o_fetch_gnt),
      .o_fetch_rvalid(o_fetch_rvalid), .o_fetch_rdata(o_fetch_rdata), .o_fetch_err(o_fetch_err),
      .i_ld_req(l_req), .i_ld_we(l_we), .i_ld_addr(l_addr), .i_ld_wdata(l_wdata),
      .o_ld_gnt(o_ld_gnt), .o_ld_rvalid(o_ld_rvalid), .o_ld_rdata(o_ld_rdata), .o_ld_err(o_ld_err),
      .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
   );

   always #5 clk = ~clk;

   // read-first synchronous array driven by the DUT
   logic [31:0] bram [0:MEM_DEPTH-1];
   always @(posedge clk) begin
      if (o_mem_en) begin
         i_mem_rdata <= bram[o_mem_addr];
         if (o_mem_we) bram[o_mem_addr] <= o_mem_wdata;
      end
   end

   // reference memory contents as the requesters should observe them
   logic [31:0] ref_mem [0:MEM_DEPTH-1];

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } rsp_t;

   rsp_t fq[$];
   rsp_t lq[$];

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   streak   = 0;   // loader grants taken while fetch has been waiting
   logic lock     = 1'b0;
   logic last_fg  = 1'b0;
   logic last_lg  = 1'b0;
   logic act_fg   = 1'b0;
   logic act_lg   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] init_word(input int i);
      return 32'hC0DE_0000 ^ (32'(i) * 32'h0000_9E37);
   endfunction

   function automatic logic legal(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (int'(a[31:2]) < MEM_DEPTH);
   endfunction

   function automatic logic [31:0] rand_addr();
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) return {$urandom_range(0, 63), 2'b00} | 32'($urandom_range(1, 3));
      if (r == 1) return 32'h0000_2000 + {$urandom_range(0, 4095), 2'b00};
      return {$urandom_range(0, 31), 2'b00};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: check grant/array side against the arbitration rules and queue the expected responses.
   task automatic do_cycle();
      logic ef, el, blk, en, we, fl, ll;
      int   fi, li;
      @(negedge clk);
      ef = 1'b0;
      el = 1'b0;
      if (!rst) begin
         ef = f_req && (!l_req || streak == MAX_LD_BURST);
         el = l_req && !ef;
      end
      blk = 1'b0;
`ifdef IMEM_WR_LOCK_EN
      blk = lock && l_we;
`endif
      fl = legal(f_addr);
      ll = legal(l_addr);
      en = (ef && fl) || (el && ll && !blk);
      we = el && ll && !blk && l_we;
      act_fg = o_fetch_gnt;
      act_lg = o_ld_gnt;
      chk("fetch_gnt", o_fetch_gnt, ef);
      chk("ld_gnt", o_ld_gnt, el);
      chk("mem_en", o_mem_en, en);
      chk("mem_we", o_mem_we, we);
      fi = int'(f_addr[12:2]);
      li = int'(l_addr[12:2]);
      if (en) chk("mem_addr", o_mem_addr, ef ? fi : li);
      if (we) chk("mem_wdata", o_mem_wdata, l_wdata);
      if (ef) fq.push_back(rsp_t'{fl ? ref_mem[fi] : NOP_INSTR, !fl, cyc + 1});
      if (el) begin
         lq.push_back(rsp_t'{(ll && !blk && !l_we) ? ref_mem[li] : 32'h0, !ll || blk, cyc + 1});
         if (ll && !blk && l_we) ref_mem[li] = l_wdata;
      end
      if (rst) begin
         streak = 0;
         lock   = 1'b0;
      end else begin
         if (!f_req || ef) streak = 0;
         else if (el && streak < MAX_LD_BURST) streak++;
         if (ef) lock = 1'b1;
      end
      last_fg = ef;
      last_lg = el;
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] a);
      f_req = 1'b1; f_addr = a; l_req = 1'b0;
      do_cycle();
      f_req = 1'b0;
   endtask

   task automatic ld(input logic we, input logic [31:0] a, input logic [31:0] d);
      l_req = 1'b1; l_we = we; l_addr = a; l_wdata = d; f_req = 1'b0;
      do_cycle();
      l_req = 1'b0;
   endtask

   // response monitor: pops expectations whenever a port presents rvalid
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (o_fetch_rvalid) begin
            if (fq.size() == 0) chk("fetch_spurious_rvalid", o_fetch_rvalid, 0);
            else begin
               e = fq.pop_front();
               chk("fetch_rsp_cycle", cyc, e.due);
               chk("fetch_rdata", o_fetch_rdata, e.rdata);
               chk("fetch_err", o_fetch_err, e.err);
            end
         end else begin
            chk("fetch_idle_rdata", o_fetch_rdata, 0);
            chk("fetch_idle_err", o_fetch_err, 0);
            if (fq.size() > 0 && fq[0].due <= cyc) begin
               chk("fetch_rvalid", o_fetch_rvalid, 1);
               e = fq.pop_front();
            end
         end
         if (o_ld_rvalid) begin
            if (lq.size() == 0) chk("ld_spurious_rvalid", o_ld_rvalid, 0);
            else begin
               e = lq.pop_front();
               chk("ld_rsp_cycle", cyc, e.due);
               chk("ld_rdata", o_ld_rdata, e.rdata);
               chk("ld_err", o_ld_err, e.err);
            end
         end else begin
            chk("ld_idle_rdata", o_ld_rdata, 0);
            chk("ld_idle_err", o_ld_err, 0);
            if (lq.size() > 0 && lq[0].due <= cyc) begin
               chk("ld_rvalid", o_ld_rvalid, 1);
               e = lq.pop_front();
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
         bram[i]    = init_word(i);
         ref_mem[i] = init_word(i);
      end
      @(posedge clk);
      #1;

      // requests during reset must not be granted nor write the array
      f_req = 1'b1; f_addr = 32'h0; l_req = 1'b1; l_we = 1'b1; l_addr = 32'h4; l_wdata = 32'hBAD0_BAD0;
      do_cycle();
      do_cycle();
      rst = 1'b0; f_req = 1'b0; l_req = 1'b0;
      do_cycle();
      ld(1'b0, 32'h4, 32'h0);

      // back-to-back fetches
      fetch(32'h0);
      fetch(32'h4);
      fetch(32'h8);
      do_cycle();

      // write then read the same word on consecutive cycles
      ld(1'b1, 32'h10, 32'hDEAD_BEEF);
      ld(1'b0, 32'h10, 32'h0);
      do_cycle();

      // faulting fetches and loader accesses
      fetch(32'h2);
      fetch(32'h2000);
      ld(1'b1, 32'h3, 32'h1234_5678);
      ld(1'b0, 32'h2004, 32'h0);
      ld(1'b0, 32'h1FFC, 32'h0);

      // both requesting continuously: L,L,L,L,F repeating
      do_cycle();
      f_req = 1'b1; f_addr = rand_addr() & 32'h0000_00FC;
      l_req = 1'b1; l_we = 1'b0; l_addr = rand_addr() & 32'h0000_00FC;
      for (int i = 0; i < 15; i++) begin
         do_cycle();
         chk("burst_fetch_gnt", act_fg, (i % 5 == 4) ? 1 : 0);
         chk("burst_ld_gnt", act_lg, (i % 5 == 4) ? 0 : 1);
         if (act_fg) f_addr = rand_addr() & 32'h0000_00FC;
         if (act_lg) begin
            l_we = 1'($urandom_range(0, 1)); l_addr = rand_addr() & 32'h0000_00FC; l_wdata = $urandom;
         end
      end
      f_req = 1'b0; l_req = 1'b0;
      do_cycle();

      // reset in the cycle after a granted read: that response shows, nothing follows
      ld(1'b0, 32'h10, 32'h0);
      rst = 1'b1; f_req = 1'b1; f_addr = 32'h8; l_req = 1'b1; l_we = 1'b1; l_addr = 32'h8; l_wdata = 32'h0BAD_0BAD;
      do_cycle();
      rst = 1'b0; f_req = 1'b0; l_req = 1'b0;
      do_cycle();
      do_cycle();

      // write before and after the first fetch grant (locked in the lock build)
      ld(1'b1, 32'h20, 32'h1111_1111);
      fetch(32'h0);
      ld(1'b1, 32'h20, 32'h2222_2222);
      ld(1'b0, 32'h20, 32'h0);
      ld(1'b0, 32'h8, 32'h0);

      // random traffic, requests held until granted
      for (int i = 0; i < 400; i++) begin
         if (!f_req || last_fg) begin
            f_req = ($urandom_range(0, 99) < 60);
            f_addr = rand_addr();
         end
         if (!l_req || last_lg) begin
            l_req = ($urandom_range(0, 99) < 60);
            l_we = 1'($urandom_range(0, 1));
            l_addr = rand_addr();
            l_wdata = $urandom;
         end
         do_cycle();
      end

      f_req = 1'b0; l_req = 1'b0;
      repeat (3) do_cycle();
      chk("fetch_queue_drained", fq.size(), 0);
      chk("ld_queue_drained", lq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
